// File: rtl/incrementor_counter_4_bit_pkg.sv
// Shared constants for the 4-bit incrementing counter.
//   CNT_W     : counter width
//   MODE_WRAP : SATURATE value selecting modulo-16 wrap (15 -> 0)
//   MODE_SAT  : SATURATE value selecting hold-at-15 with sticky sat flag
package incrementor_counter_4_bit_pkg;
  localparam int CNT_W     = 4;
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;
endpackage

// File: rtl/and_g.sv
// Two-input AND primitive.
//   a, b : inputs
//   y    : a & b
module and_g (
  output logic y,
  input  logic a,
  input  logic b
);
  assign y = a & b;
endmodule

// File: rtl/half_adder.sv
// NOR-only half adder.
//   a, b : addend bits
//   s    : sum   (a ^ b)
//   c    : carry (a & b)
module half_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);
  logic n_ab;
  logic n_a_nab;
  logic n_b_nab;
  logic xnor_ab;
  logic a_n;
  logic b_n;

  // XNOR from NOR gates, then a NOR used as an inverter gives XOR.
  assign n_ab    = ~(a | b);
  assign n_a_nab = ~(a | n_ab);
  assign n_b_nab = ~(b | n_ab);
  assign xnor_ab = ~(n_a_nab | n_b_nab);
  assign s       = ~(xnor_ab | xnor_ab);

  // a & b == NOR(~a, ~b), inversions also done with NOR.
  assign a_n = ~(a | a);
  assign b_n = ~(b | b);
  assign c   = ~(a_n | b_n);
endmodule

// File: rtl/incrementor_4_bit.sv
// Combinational +1 incrementor: four half adders in a ripple chain.
//   X  : input value
//   Y  : X + 1 (modulo 16)
//   co : carry out of the top stage, high only when X is 15
module incrementor_4_bit
  import incrementor_counter_4_bit_pkg::*;
(
  output logic [CNT_W-1:0] Y,
  output logic             co,
  input  logic [CNT_W-1:0] X
);
  logic [CNT_W:0] carry;

  // The constant +1 enters as stage-0's B input.
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < CNT_W; i++) begin : g_stage
      half_adder u_ha (
        .s (Y[i]),
        .c (carry[i+1]),
        .a (X[i]),
        .b (carry[i])
      );
    end
  endgenerate

  assign co = carry[CNT_W];
endmodule

// File: rtl/not_g.sv
// Inverter primitive.
//   a : input
//   y : ~a
module not_g (
  output logic y,
  input  logic a
);
  assign y = ~a;
endmodule

// File: rtl/or_g.sv
// Two-input OR primitive.
//   a, b : inputs
//   y    : a | b
module or_g (
  output logic y,
  input  logic a,
  input  logic b
);
  assign y = a | b;
endmodule

// File: rtl/incrementor_counter_4_bit.sv
// Registered 4-bit up-counter with ripple half-adder next-state logic.
//   RESET_VAL : count value forced by rst
//   SATURATE  : MODE_WRAP wraps 15 -> 0, MODE_SAT holds at 15
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : increment enable
//   load      : synchronous load of ld_val (beats en)
//   ld_val    : load value
//   count     : registered counter value
//   tc        : combinational terminal count (count == 15)
//   wrap      : one-cycle pulse in the cycle after a 15 -> 0 step
//   sat       : sticky flag, set by an increment blocked at 15; cleared by load/rst
module incrementor_counter_4_bit
  import incrementor_counter_4_bit_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);
  logic [CNT_W-1:0] inc;
  logic             co;
  logic             sat_mode;
  logic             wrap_mode;
  logic             load_n;
  logic             en_eff;
  logic             en_at_top;
  logic             blocked;
  logic             blocked_n;
  logic             do_inc;
  logic             upd;
  logic             hold;
  logic             wrap_d;
  logic             sat_keep;
  logic             sat_d;
  logic [CNT_W-1:0] count_d;

  incrementor_4_bit u_inc (
    .Y  (inc),
    .co (co),
    .X  (count)
  );

  assign sat_mode = SATURATE;

  not_g u_mode_n (.y(wrap_mode), .a(sat_mode));
  not_g u_load_n (.y(load_n),    .a(load));

  // Increment request that survives the load override.
  and_g u_en_eff (.y(en_eff),    .a(en),     .b(load_n));
  and_g u_en_top (.y(en_at_top), .a(en_eff), .b(co));

  // In saturate mode an increment at 15 is swallowed instead of wrapping.
  and_g u_blocked   (.y(blocked),   .a(en_at_top), .b(sat_mode));
  not_g u_blocked_n (.y(blocked_n), .a(blocked));
  and_g u_do_inc    (.y(do_inc),    .a(en_eff),    .b(blocked_n));

  // Hold whenever neither load nor a real increment selects a new value.
  or_g  u_upd  (.y(upd),  .a(load), .b(do_inc));
  not_g u_hold (.y(hold), .a(upd));

  // One-hot select mux: load / increment / hold.
  genvar i;
  generate
    for (i = 0; i < CNT_W; i++) begin : g_mux
      logic sel_ld;
      logic sel_inc;
      logic sel_hold;
      logic or_lo;
      and_g u_a_ld   (.y(sel_ld),   .a(ld_val[i]), .b(load));
      and_g u_a_inc  (.y(sel_inc),  .a(inc[i]),    .b(do_inc));
      and_g u_a_hold (.y(sel_hold), .a(count[i]),  .b(hold));
      or_g  u_o_lo   (.y(or_lo),      .a(sel_ld), .b(sel_inc));
      or_g  u_o_hi   (.y(count_d[i]), .a(or_lo),  .b(sel_hold));
    end
  endgenerate

  and_g u_wrap_d (.y(wrap_d), .a(en_at_top), .b(wrap_mode));

  // sat is sticky until load; a blocked increment (already gated by load_n) sets it.
  or_g  u_sat_keep (.y(sat_keep), .a(sat),      .b(blocked));
  and_g u_sat_d    (.y(sat_d),    .a(sat_keep), .b(load_n));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
      sat   <= sat_d;
    end
  end

  assign tc = &count;
endmodule

// File: tb/tb_incrementor_counter_4_bit.sv
module tb_incrementor_counter_4_bit;
  import incrementor_counter_4_bit_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_w, load_w;
  logic [3:0] ld_val_w;
  logic [3:0] count_w;
  logic       tc_w, wrap_w, sat_w;
  logic       en_s, load_s;
  logic [3:0] ld_val_s;
  logic [3:0] count_s;
  logic       tc_s, wrap_s, sat_s;

  int checks   = 0;
  int failures = 0;

  incrementor_counter_4_bit #(.RESET_VAL(4'b0000), .SATURATE(MODE_WRAP)) u_dut_w (
    .clk(clk), .rst(rst), .en(en_w), .load(load_w), .ld_val(ld_val_w),
    .count(count_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w)
  );

  incrementor_counter_4_bit #(.RESET_VAL(4'b0101), .SATURATE(MODE_SAT)) u_dut_s (
    .clk(clk), .rst(rst), .en(en_s), .load(load_s), .ld_val(ld_val_s),
    .count(count_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic [3:0] ld_val;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    logic [3:0] exp_seq_s[5];
    logic       exp_sat_s[5];

    vecs[0]  = '{1'b1, 1'b0, 4'd6,  4'd6,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  4'd6,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  4'd6,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  4'd6,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  4'd6,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'd6,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd10, 4'd10, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd0,  4'd11, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'd0,  4'd1,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'd3,  4'd3,  1'b0, 1'b0};

    exp_seq_s = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
    exp_sat_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    en_w = 1'b0; load_w = 1'b0; ld_val_w = 4'd0;
    en_s = 1'b0; load_s = 1'b0; ld_val_s = 4'd0;

    #12;
    check("reset_count_w", count_w, 4'd0);
    check("reset_wrap_w", {3'b0, wrap_w}, 4'd0);
    check("reset_sat_w", {3'b0, sat_w}, 4'd0);
    check("reset_count_s", count_s, 4'd5);
    check("reset_sat_s", {3'b0, sat_s}, 4'd0);
    rst = 1'b0;

    en_w = 1'b1;
    repeat (9) step();
    check("count_to_9", count_w, 4'd9);

    // Asynchronous reset in mid-cycle: values must change before any edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", count_w, 4'd0);
    check("async_rst_wrap", {3'b0, wrap_w}, 4'd0);
    check("async_rst_sat", {3'b0, sat_w}, 4'd0);
    check("async_rst_count_s", count_s, 4'd5);
    #1;
    rst = 1'b0;

    // First edge after reset release increments; full lap 1..15,0.
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_cnt = 4'(i);
      check($sformatf("lap_count_%0d", i), count_w, exp_cnt);
      check($sformatf("lap_tc_%0d", i), {3'b0, tc_w}, {3'b0, (i == 15)});
      check($sformatf("lap_wrap_%0d", i), {3'b0, wrap_w}, {3'b0, (i == 16)});
    end

    for (int i = 0; i < 16; i++) begin
      load_w   = vecs[i].load;
      en_w     = vecs[i].en;
      ld_val_w = vecs[i].ld_val;
      step();
      check($sformatf("vec%0d_count", i), count_w, vecs[i].count);
      check($sformatf("vec%0d_tc", i), {3'b0, tc_w}, {3'b0, vecs[i].tc});
      check($sformatf("vec%0d_wrap", i), {3'b0, wrap_w}, {3'b0, vecs[i].wrap});
    end

    for (int v = 0; v < 16; v++) begin
      load_w = 1'b1; en_w = 1'b0; ld_val_w = 4'(v);
      step();
      load_w = 1'b0; en_w = 1'b1;
      step();
      exp_cnt = 4'(v + 1);
      check($sformatf("exh_count_%0d", v), count_w, exp_cnt);
      check($sformatf("exh_wrap_%0d", v), {3'b0, wrap_w}, {3'b0, (v == 15)});
    end
    en_w = 1'b0;
    check("wrap_mode_sat_low", {3'b0, sat_w}, 4'd0);

    // Saturate mode.
    load_s = 1'b1; ld_val_s = 4'd13;
    step();
    check("sat_load13", count_s, 4'd13);
    load_s = 1'b0; en_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_seq_count_%0d", i), count_s, exp_seq_s[i]);
      check($sformatf("sat_seq_sat_%0d", i), {3'b0, sat_s}, {3'b0, exp_sat_s[i]});
      check($sformatf("sat_seq_wrap_%0d", i), {3'b0, wrap_s}, 4'd0);
    end
    check("sat_tc_at15", {3'b0, tc_s}, 4'd1);
    en_s = 1'b0;
    step();
    check("sat_sticky_idle", {3'b0, sat_s}, 4'd1);
    load_s = 1'b1; ld_val_s = 4'd0;
    step();
    check("sat_load0_count", count_s, 4'd0);
    check("sat_load0_sat", {3'b0, sat_s}, 4'd0);
    load_s = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
